pixel_stream_out_buffer: RTL and testbench

Parametrised output stage of the 3x3 kernel pipeline. It sits between the kernel core's pixel output and the downstream stream consumer, and provides:
- an internal synchronous FIFO;
- slack-aware input back-pressure;
- line and frame framing flags;
- a clearable frame-done interrupt and a sticky overflow flag.

It replaces the fixed-depth vendor FIFO stage with a native, fully parametrised buffer.

---
 rtl/pixel_stream_out_buffer_if.sv | 25 ++
 rtl/pixel_stream_out_buffer.sv | 102 ++++++++++
 tb/tb_pixel_stream_out_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_out_buffer_if.sv
// Pixel path between the kernel core, the output buffer and the downstream consumer.
// Handshake: a pixel moves to the consumer on a rising edge where outPixelValid && outPixelReady;
// the core side has no ready, inPixelReady is an advisory throttle and pixInValid is a plain push request.
interface pixel_stream_out_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pixIn;
    logic                  pixInValid;
    logic                  inPixelReady;
    logic [DATA_WIDTH-1:0] outPixel;
    logic                  outPixelValid;
    logic                  outPixelReady;
    logic                  outSof;
    logic                  outEol;

    modport master (
        output pixIn, pixInValid, outPixelReady,
        input  inPixelReady, outPixel, outPixelValid, outSof, outEol
    );

    modport slave (
        input  pixIn, pixInValid, outPixelReady,
        output inPixelReady, outPixel, outPixelValid, outSof, outEol
    );
endinterface

// File: rtl/pixel_stream_out_buffer.sv
// Output stage of the 3x3 kernel pipeline: first-word fall-through FIFO with slack-aware
// back-pressure, line/frame framing flags, frame-done interrupt and sticky overflow.
module pixel_stream_out_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int SLACK      = 4,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    pixel_stream_out_buffer_if.slave px,
    output logic [$clog2(DEPTH):0]   fillLevel,
    input  logic                     irqClear,
    output logic                     interrupt,
    output logic                     overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int COLW = $clog2(IMG_WIDTH);
    localparam int ROWW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic [CW-1:0]         count;
    logic [COLW-1:0]       col;
    logic [ROWW-1:0]       row;

    logic full;
    logic push;
    logic pop;
    logic lastCol;
    logic lastRow;

    always_comb begin
        full    = (count == CW'(DEPTH));
        lastCol = (col == COLW'(IMG_WIDTH - 1));
        lastRow = (row == ROWW'(IMG_HEIGHT - 1));
        pop     = px.outPixelValid && px.outPixelReady;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push    = px.pixInValid && (!full || pop);
    end

    assign px.outPixelValid = !rst && (count != '0);
    assign px.outPixel      = mem[rdPtr];
    assign px.outSof        = px.outPixelValid && (col == '0) && (row == '0);
    assign px.outEol        = px.outPixelValid && lastCol;
    // SLACK entries stay free to absorb pixels already inside the core when ready drops.
    assign px.inPixelReady  = !rst && (count < CW'(DEPTH - SLACK));
    assign fillLevel        = count;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wrPtr] <= px.pixIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            col       <= '0;
            row       <= '0;
            interrupt <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                if (lastCol) begin
                    col <= '0;
                    row <= lastRow ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // Setting on the frame's last pop outranks a simultaneous clear.
            if (pop && lastCol && lastRow) begin
                interrupt <= 1'b1;
            end else if (irqClear) begin
                interrupt <= 1'b0;
            end

            if (px.pixInValid && !push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_out_buffer.sv
// Bench for pixel_stream_out_buffer: directed scenarios plus random traffic, checked by a
// queue-based reference model and a monitor that compares every output each cycle.
module tb_pixel_stream_out_buffer;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int SLACK  = 4;
    localparam int W      = 4;
    localparam int H      = 2;
    localparam int FRAME  = W * H;
    localparam int FLW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           irqClear = 1'b0;
    logic [FLW-1:0] fillLevel;
    logic           interrupt;
    logic           overflow;

    pixel_stream_out_buffer_if #(.DATA_WIDTH(DW)) bus ();

    pixel_stream_out_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .SLACK(SLACK), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst), .px(bus.slave), .fillLevel(fillLevel),
        .irqClear(irqClear), .interrupt(interrupt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    int            m_pops  = 0;
    logic          m_irq   = 1'b0;
    logic          m_ovf   = 1'b0;
    bit            started = 1'b0;
    int            mon_pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, queue of accepted pixels, frame position by pop count.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_pops  = 0;
            m_irq   = 1'b0;
            m_ovf   = 1'b0;
            started = 1'b1;
        end else begin
            bit do_pop;
            bit do_push;
            bit set_irq;
            do_pop  = (m_count > 0) && bus.outPixelReady;
            do_push = bus.pixInValid && ((m_count < DEPTH) || do_pop);
            set_irq = 1'b0;
            if (bus.pixInValid && !do_push) m_ovf = 1'b1;
            if (do_pop) begin
                if (m_pops % FRAME == FRAME - 1) set_irq = 1'b1;
                m_pops++;
            end
            if (set_irq) m_irq = 1'b1;
            else if (irqClear) m_irq = 1'b0;
            if (do_push) exp_q.push_back(bus.pixIn);
            m_count = m_count + int'(do_push) - int'(do_pop);
        end
    end

    // Monitor: sample mid-cycle, compare status, pop the scoreboard on each handshake.
    always @(negedge clk) begin
        if (started) begin
            logic exp_valid;
            exp_valid = !rst && (m_count != 0);
            if (rst) mon_pos = 0;
            check("outPixelValid", 32'(bus.outPixelValid), 32'(exp_valid));
            check("inPixelReady", 32'(bus.inPixelReady), 32'(!rst && (m_count < DEPTH - SLACK)));
            check("fillLevel", 32'(fillLevel), 32'(m_count));
            check("interrupt", 32'(interrupt), 32'(m_irq));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("outSof", 32'(bus.outSof), 32'(exp_valid && (mon_pos % FRAME == 0)));
            check("outEol", 32'(bus.outEol), 32'(exp_valid && (mon_pos % W == W - 1)));
            if (!rst && bus.outPixelValid && bus.outPixelReady) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_model", 32'(1), 32'(0));
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check("outPixel", 32'(bus.outPixel), 32'(e));
                end
                mon_pos++;
            end
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        bus.pixInValid    = v;
        bus.pixIn         = d;
        bus.outPixelReady = rdy;
        irqClear          = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic drain(input int n, input logic clr);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, clr);
    endtask

    initial begin
        bus.pixInValid    = 1'b0;
        bus.pixIn         = '0;
        bus.outPixelReady = 1'b0;

        // Reset held with pixInValid high, then a single push.
        do_reset(3);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        drain(3, 1'b0);

        // Streaming one full frame, interrupt held until cleared.
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'h10 + i), 1'b1, 1'b0);
        drain(4, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        drain(2, 1'b0);

        // Back-pressure up to full, then one dropped push.
        do_reset(1);
        for (int i = 0; i < 17; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        drain(20, 1'b0);

        // Full FIFO with simultaneous push and pop.
        do_reset(1);
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        drain(20, 1'b0);

        // irqClear coincident with the final-pixel pop, then alone.
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'h60 + i), 1'b1, 1'b1);
        drain(4, 1'b1);

        // Reset mid-frame after five pops.
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        drain(5, 1'b0);
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'h90 + i), 1'b1, 1'b0);
        drain(4, 1'b0);

        // Random traffic; the core mostly honours inPixelReady.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0) && (bus.inPixelReady || ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            cyc(v, DW'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0));
            rst = 1'b0;
        end
        drain(DEPTH + 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
